ripple_counter: RTL and testbench
=================================

Name: ripple_counter

Overview:
- Free-running WIDTH-bit binary up-counter with synchronous clear, clocked by a single clock.
- "Ripple" refers to the carry chain: stage i toggles when all lower stages are 1.
- All stages are clocked by the same `clock`. No stage is clocked from another stage's output.
- Used as a simple event/cycle counter and as a reference block for counter verification.

Parameters:
- WIDTH, 4, number of counter bits (legal range 1..32).

Ports:
- clock  input  1  rising-edge clock; the only clock in the block.
- clear  input  1  reset; synchronous, active-high. Forces the count to 0 at the next rising edge.
- out  output  WIDTH  current count value, driven directly from registers.
- Declaration order in the module header is fixed as (out, clock, clear) so that positional instantiation works. Named connection is also supported.

Behaviour:
- One clock; reset is synchronous and active-high (clock port `clock`, reset port `clear`).
- All state changes occur on the rising edge of `clock` only. `clear` has no asynchronous effect.
- Clear: if `clear`=1 at a rising edge, out <= 0 at that edge. Clear has priority over counting.
- Count: if `clear`=0 at a rising edge, out <= out + 1 (modulo 2^WIDTH).
- Carry-chain form: stage 0 toggles every edge; stage i toggles iff bits [i-1:0] are all 1. The result equals a plain increment.
- Latency: out reflects the new value immediately after the edge; there are no pipeline stages.
- Wrap-around: all-ones (4'b1111 at default) -> 0 on the next counting edge. There is no terminal-count flag and no saturation.
- Power-up: out is undefined until the first rising edge with `clear`=1. The block has no initial values. Benches must assert `clear` for at least one edge.
- Clear mid-count: the count is discarded at the first edge where `clear`=1. It stays 0 for every edge `clear` is held. Counting resumes from 0, giving 1 on the first edge after `clear` deasserts.
- `clear` toggling between edges has no effect; only its value at the edge is sampled.
- No enable input: the counter advances on every non-clear edge.

Optional Feature:
- Macro RIPPLE_COUNTER_DOWN_EN.
- Defined: the counter counts down instead of up. Stage i toggles iff bits [i-1:0] are all 0. From 0 it wraps to all-ones (4'b1111 at default). Clear still forces 0, and the first edge after clear yields all-ones.
- Not defined: up-counting exactly as in Behaviour.
- Ports and parameters are identical in both builds.

Test Plan:
- Clock period 20 (edges at 10, 30, 50, ...); `clear`=1 from t=0 to t=34 -> out=0 after the edges at t=10 and t=30.
- `clear`=0 from t=34 -> out=1 at t=50, 2 at t=70, ..., 10 (4'b1010) at t=230, one increment per edge.
- `clear`=1 at t=234, held to t=284 -> out=0 at t=250 and remains 0 at t=270.
- `clear`=0 at t=284 -> out=1 at t=290, rising to 6 (4'b0110) at t=390.
- Wrap-around: after clear, 15 counting edges give 4'b1111; the 16th edge gives 4'b0000; the 17th gives 4'b0001.
- `clear` pulse that rises and falls between two edges -> out unaffected. With RIPPLE_COUNTER_DOWN_EN defined, the first edge after clear gives 4'b1111, then 4'b1110.

Source files
------------

// File: rtl/ripple_counter.sv
// WIDTH-bit synchronous counter built from a per-stage toggle (carry) chain.
// Define RIPPLE_COUNTER_DOWN_EN to count down instead of up.
module ripple_counter #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] out,
  input  logic             clock,
  input  logic             clear
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Stage i toggles when every lower stage is at its carry value (1 up, 0 down).
  always_comb begin
    logic carry;
    count_d = count_q;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      count_d[i] = count_q[i] ^ carry;
`ifdef RIPPLE_COUNTER_DOWN_EN
      carry = carry & ~count_q[i];
`else
      carry = carry & count_q[i];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: tb/tb_ripple_counter.sv
// Directed bench for ripple_counter: clear behaviour, counting, wrap-around
// and clear pulses that fall between clock edges.
module tb_ripple_counter;

  logic       clock;
  logic       clear;
  logic [3:0] out;

  int checks;
  int errors;

  typedef struct {
    logic       clr;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[20];

  ripple_counter #(.WIDTH(4)) dut (
    .out  (out),
    .clock(clock),
    .clear(clear)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Expected value k counting edges after a clear, in either direction.
  function automatic logic [3:0] stepsFromClear(input int k);
    logic [3:0] v;
    v = 4'(k);
`ifdef RIPPLE_COUNTER_DOWN_EN
    v = 4'd0 - v;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, out, exp, $time);
    end
  endtask

  // Drive clear before an edge, then sample on the following falling edge.
  task automatic applyStimulus(input logic clr);
    clear = clr;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before t=100000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] held;
    checks = 0;
    errors = 0;
    clear  = 1'b1;

    vecs[0] = '{1'b1, 4'd0};
    vecs[1] = '{1'b1, 4'd0};
    for (int k = 1; k <= 10; k++) vecs[1 + k] = '{1'b0, stepsFromClear(k)};
    vecs[12] = '{1'b1, 4'd0};
    vecs[13] = '{1'b1, 4'd0};
    for (int k = 1; k <= 6; k++) vecs[13 + k] = '{1'b0, stepsFromClear(k)};

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Wrap-around: sixteen counting edges return to zero, then continue.
    applyStimulus(1'b1);
    checkOutput("wrap_clear", 4'd0);
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1'b0);
      if (k == 15) checkOutput("wrap_edge15", stepsFromClear(15));
      if (k == 16) checkOutput("wrap_edge16", 4'd0);
      if (k == 17) checkOutput("wrap_edge17", stepsFromClear(17));
    end

    // A clear pulse that rises and falls between edges must be ignored.
    held = out;
    #3 clear = 1'b1;
    #3 clear = 1'b0;
    #1 checkOutput("glitch_no_async", held);
    @(posedge clock);
    @(negedge clock);
    checkOutput("glitch_next_edge", stepsFromClear(18));
    applyStimulus(1'b0);
    checkOutput("glitch_after", stepsFromClear(19));

    // Clear priority and resume direction after a single clear edge.
    applyStimulus(1'b1);
    checkOutput("resume_clear", 4'd0);
    applyStimulus(1'b0);
    checkOutput("resume_first", stepsFromClear(1));
    applyStimulus(1'b0);
    checkOutput("resume_second", stepsFromClear(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
